mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, byte-enabled, synchronous-read memory between the instruction-fetch port and the load/store port of the 3-stage core.
- Grants at most one transaction per cycle. Data has fixed priority over instruction, with a starvation escape for instruction fetch.
- Tracks which port owns the registered read data returned one cycle later, and routes it back.
- Checks address range and supports squashing an in-flight fetch on branch redirect.

Parameters:
- MEM_SIZE, 4096, memory size in bytes; must be a power of two and match the attached memory.
- STARVE_LIMIT, 4, consecutive cycles a pending fetch may lose arbitration before it is forced through; must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  fetch request
- i_addr  in  30  fetch word address [31:2]
- i_flush  in  1  squash fetch response
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch response valid
- i_rdata  out  32  fetch data
- i_err  out  1  fetch out-of-range, qualifies i_rvalid
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  30  data word address [31:2]
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  data response valid (loads and stores)
- d_rdata  out  32  data response word
- d_err  out  1  data out-of-range, qualifies d_rvalid
- mem_read_ready  out  1  memory read enable
- mem_write_ready  out  1  memory write enable
- mem_read_address  out  30  memory read word address
- mem_write_address  out  30  memory write word address
- mem_write_data  out  32  memory write data
- mem_write_byte  out  4  memory byte enables
- mem_read_data  in  32  registered memory read data (1-cycle latency)

Behaviour:
- Clocking: single clock domain, clk. Reset is synchronous active-low (rst_n).
- Reset values while rst_n=0: i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, mem_read_ready and mem_write_ready are all 0. Response tag = NONE, starvation counter = 0.
- Handshake: a transaction is accepted when req & gnt in cycle N. Grants are combinational from the current requests and state. Requesters cannot back-pressure responses. One accept per cycle, fully pipelined, no bubbles.
- Arbitration:
  - Only d_req: d_gnt = 1.
  - Only i_req: i_gnt = 1.
  - Both: d_gnt = 1, unless starve_cnt == STARVE_LIMIT, in which case i_gnt = 1 and d_gnt = 0.
- Starvation counter:
  - Increments when i_req & !i_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 on i_gnt or !i_req.
- Range check: an address is out of range if addr ≥ MEM_SIZE/4.
  - An out-of-range transaction is still granted, but mem_read_ready = 0 and mem_write_ready = 0.
  - Its response in N+1 has err = 1 and rdata = 0.
- Memory drive in cycle N (accepted, in range):
  - mem_read_ready = 1 and mem_read_address = granted address.
  - For a store, additionally mem_write_ready = 1, mem_write_address = d_addr, mem_write_byte = d_be, mem_write_data = d_wdata. Because read and write use the same address, the store response carries the merged post-write word.
  - When idle, address and data outputs follow the d_* inputs; both enables are 0.
- Response tag register, updated every cycle:
  - Takes the value NONE / INSTR / DATA for the accepted owner, plus a registered err bit.
  - Cycle N+1: the owner's rvalid = 1 and its rdata = mem_read_data (or 0 on err).
  - The non-owner's rvalid = 0 and its rdata holds mem_read_data; it is don't-care.
- i_flush:
  - When i_flush = 1, i_rvalid and i_err are forced 0 in that cycle.
  - A fetch granted in a cycle where i_flush = 1 is tagged NONE, so no response is produced.
  - i_flush does not affect i_gnt or the data port.
- Reset mid-transaction: an outstanding response is dropped (tag = NONE) and no rvalid is produced in the cycle after reset deasserts.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e
  - localparam WORD_ADDR_W = 30
  - function in_range(addr, size)
- No sub-module. Arbitration and tag tracking live in one module.
- A top-level wrapper instantiates this block together with the unified memory.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with both req = 1 → all gnt/rvalid/mem enables are 0. Release → d_gnt = 1 in the first cycle.
- Fetch of a word at word address 0x010 holding 0xDEADBEEF: i_req = 1, i_addr = 0x010, d_req = 0 → i_gnt = 1 in N; i_rvalid = 1 and i_rdata = 0xDEADBEEF in N+1; d_rvalid = 0.
- Store then load, back-to-back: store d_addr = 0x020, d_wdata = 0x11223344, d_be = 4'b0011 over an old word 0xAABBCCDD; then a load of 0x020 in the next cycle → store response 0xAABB3344, load response 0xAABB3344.
- Starvation: i_req and d_req held high for 10 cycles with STARVE_LIMIT = 4 → d_gnt in cycles 0–3, i_gnt in cycle 4, counter cleared, then d_gnt in cycles 5–8 and i_gnt in cycle 9.
- Flush: fetch granted in N, i_flush = 1 in N+1 → i_rvalid = 0. Fetch granted with i_flush = 1 in N → i_rvalid = 0 in N+1.
- Range: d_addr = 0x400 with MEM_SIZE = 4096, d_we = 1 → d_gnt = 1, mem_write_ready = 0; d_rvalid = 1, d_err = 1, d_rdata = 0 in N+1; memory contents unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
//   owner_e   : which requester owns the read data returning next cycle
//   tag_t     : registered response tag (owner + out-of-range flag)
//   in_range  : word-address bounds check against a byte-sized memory
package mem_arb_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   err;
  } tag_t;

  localparam tag_t TAG_IDLE = '{owner: OWN_NONE, err: 1'b0};

  // True when the word address falls inside a memory of 'size' bytes.
  function automatic logic in_range(input logic [WORD_ADDR_W-1:0] addr,
                                    input int unsigned            size);
    return (32'(addr) < (size >> 2));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the
// unified single-port memory.
//   i_*   : instruction-fetch request/response
//   d_*   : load/store request/response
//   mem_* : memory-side enables, addresses, write data and read data
// Modports: slave = arbiter view, master = core + memory (environment) view.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  // Fetch port
  logic                   i_req;
  logic [WORD_ADDR_W-1:0] i_addr;
  logic                   i_flush;
  logic                   i_gnt;
  logic                   i_rvalid;
  logic [DATA_W-1:0]      i_rdata;
  logic                   i_err;

  // Load/store port
  logic                   d_req;
  logic                   d_we;
  logic [WORD_ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0]      d_wdata;
  logic [BE_W-1:0]        d_be;
  logic                   d_gnt;
  logic                   d_rvalid;
  logic [DATA_W-1:0]      d_rdata;
  logic                   d_err;

  // Memory side
  logic                   mem_read_ready;
  logic                   mem_write_ready;
  logic [WORD_ADDR_W-1:0] mem_read_address;
  logic [WORD_ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0]      mem_write_data;
  logic [BE_W-1:0]        mem_write_byte;
  logic [DATA_W-1:0]      mem_read_data;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_gnt, i_rvalid, i_rdata, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_read_ready, mem_write_ready, mem_read_address,
    output mem_write_address, mem_write_data, mem_write_byte,
    input  mem_read_data
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_read_ready, mem_write_ready, mem_read_address,
    input  mem_write_address, mem_write_data, mem_write_byte,
    output mem_read_data
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, byte-enabled, synchronous-read memory between the
// instruction-fetch and load/store ports. Data wins arbitration unless a
// pending fetch has lost STARVE_LIMIT times in a row. The owner of next
// cycle's read data is tagged so the registered memory output is routed back
// to the right requester; out-of-range accesses are granted but never reach
// the memory and answer with err=1, rdata=0.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (fetch, load/store and memory signals)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE     = 4096,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Elaboration-time parameter sanity
  if ((MEM_SIZE < 4) || ((MEM_SIZE & (MEM_SIZE - 1)) != 0)) begin : g_bad_mem_size
    $error("mem_port_arbiter: MEM_SIZE must be a power of two >= 4");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  logic [CNT_W-1:0]       starve_q, starve_d;
  tag_t                   tag_q, tag_d;

  logic                   force_i;
  logic                   i_gnt_w;
  logic                   d_gnt_w;
  logic                   accept;
  logic                   accept_ok;
  logic [WORD_ADDR_W-1:0] sel_addr;
  logic                   i_own;
  logic                   d_own;

  // Arbitration: data first, fetch forced through once the counter saturates.
  // Grants are held low during reset.
  always_comb begin
    force_i   = 1'b0;
    i_gnt_w   = 1'b0;
    d_gnt_w   = 1'b0;
    accept    = 1'b0;
    accept_ok = 1'b0;
    sel_addr  = bus.d_addr;

    force_i   = bus.i_req & bus.d_req & (starve_q == LIMIT);
    i_gnt_w   = rst_n & bus.i_req & (~bus.d_req | force_i);
    d_gnt_w   = rst_n & bus.d_req & ~force_i;
    accept    = i_gnt_w | d_gnt_w;
    if (i_gnt_w) begin
      sel_addr = bus.i_addr;
    end
    accept_ok = accept & in_range(sel_addr, MEM_SIZE);
  end

  // Starvation counter: counts consecutive lost cycles of a pending fetch.
  always_comb begin
    starve_d = '0;
    if (bus.i_req && !i_gnt_w) begin
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + CNT_W'(1);
    end
  end

  // Response tag: a fetch accepted under flush is dropped at the source.
  always_comb begin
    tag_d = TAG_IDLE;
    if (i_gnt_w) begin
      tag_d.owner = bus.i_flush ? OWN_NONE : OWN_INSTR;
    end else if (d_gnt_w) begin
      tag_d.owner = OWN_DATA;
    end
    tag_d.err = accept & ~accept_ok;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
      tag_q    <= TAG_IDLE;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  // Memory drive; write shares the read address so a store returns the merged word.
  assign bus.i_gnt             = i_gnt_w;
  assign bus.d_gnt             = d_gnt_w;
  assign bus.mem_read_ready    = accept_ok;
  assign bus.mem_write_ready   = accept_ok & d_gnt_w & bus.d_we;
  assign bus.mem_read_address  = sel_addr;
  assign bus.mem_write_address = bus.d_addr;
  assign bus.mem_write_data    = bus.d_wdata;
  assign bus.mem_write_byte    = bus.d_be;

  // Response routing; non-owner rdata simply mirrors the memory output.
  assign i_own = rst_n & (tag_q.owner == OWN_INSTR);
  assign d_own = rst_n & (tag_q.owner == OWN_DATA);

  assign bus.i_rvalid = i_own & ~bus.i_flush;
  assign bus.i_err    = i_own & ~bus.i_flush & tag_q.err;
  assign bus.i_rdata  = (i_own && tag_q.err) ? '0 : bus.mem_read_data;

  assign bus.d_rvalid = d_own;
  assign bus.d_err    = d_own & tag_q.err;
  assign bus.d_rdata  = (d_own && tag_q.err) ? '0 : bus.mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a spec-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned MEM_SIZE     = 4096;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned WORDS        = MEM_SIZE / 4;
  localparam int unsigned AW           = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_SIZE    (MEM_SIZE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Attached memory: write-first, registered read, plus a preload port.
  logic [31:0]   mem     [WORDS];
  logic [31:0]   ref_mem [WORDS];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  always @(posedge clk) begin : attached_mem
    logic [31:0] w;
    if (pl_en) mem[pl_addr] = pl_data;
    w = mem[bus.mem_write_address[AW-1:0]];
    if (bus.mem_write_ready) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_write_byte[b]) w[8*b +: 8] = bus.mem_write_data[8*b +: 8];
      mem[bus.mem_write_address[AW-1:0]] = w;
    end
    if (bus.mem_read_ready) bus.mem_read_data <= mem[bus.mem_read_address[AW-1:0]];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_flush = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
  endtask

  task automatic preload(input int unsigned a, input logic [31:0] v);
    pl_en   = 1'b1;
    pl_addr = AW'(a);
    pl_data = v;
    ref_mem[a] = v;
    next_cycle();
    pl_en   = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.i_addr = 30'h5;
    bus.d_addr = 30'h6;
    bus.d_we   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.mem_read_ready,
           bus.mem_write_ready} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: got %b want 000000", k,
                 {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.mem_read_ready,
                  bus.mem_write_ready});
      end
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_release: got %b want 0100",
               {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid});
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, ref_mem[6]}) begin
      n_err++;
      $display("FAIL reset_first_load: got %b %b %h want 1 0 %h",
               bus.d_rvalid, bus.d_err, bus.d_rdata, ref_mem[6]);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h11;
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.i_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_rvalid: got %b want 0", bus.i_rvalid);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_reset_after: got %b want 00", {bus.i_rvalid, bus.d_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_fetch();
    preload(32'h10, 32'hDEADBEEF);
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h10;
    @(negedge clk);
    n_cmp++;
    if ({bus.i_gnt, bus.d_gnt, bus.mem_read_ready, bus.mem_read_address} !== {3'b101, 30'h10}) begin
      n_err++;
      $display("FAIL fetch_grant: got %b%b%b addr %h want 101 addr 010",
               bus.i_gnt, bus.d_gnt, bus.mem_read_ready, bus.mem_read_address);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.i_rvalid, bus.i_err, bus.d_rvalid, bus.i_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL fetch_resp: got v%b e%b dv%b %h want v1 e0 dv0 deadbeef",
               bus.i_rvalid, bus.i_err, bus.d_rvalid, bus.i_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    preload(32'h20, 32'hAABBCCDD);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 30'h20;
    bus.d_wdata = 32'h11223344;
    bus.d_be    = 4'b0011;
    ref_mem[32'h20] = 32'hAABB3344;
    @(negedge clk);
    n_cmp++;
    if ({bus.d_gnt, bus.mem_write_ready, bus.mem_write_byte, bus.mem_write_address} !==
        {2'b11, 4'b0011, 30'h20}) begin
      n_err++;
      $display("FAIL store_drive: got g%b we%b be%b a%h want g1 we1 be0011 a020",
               bus.d_gnt, bus.mem_write_ready, bus.mem_write_byte, bus.mem_write_address);
    end
    next_cycle();
    bus.d_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.d_gnt, bus.d_rvalid, bus.d_rdata} !== {2'b11, 32'hAABB3344}) begin
      n_err++;
      $display("FAIL store_resp: got g%b v%b %h want g1 v1 aabb3344",
               bus.d_gnt, bus.d_rvalid, bus.d_rdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'hAABB3344}) begin
      n_err++;
      $display("FAIL load_after_store: got v%b %h want v1 aabb3344", bus.d_rvalid, bus.d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h30;
    bus.d_req  = 1'b1;
    bus.d_addr = 30'h31;
    for (int k = 0; k < 10; k++) begin
      logic [1:0] exp;
      exp = (k == 4 || k == 9) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_cmp++;
      if ({bus.i_gnt, bus.d_gnt} !== exp) begin
        n_err++;
        $display("FAIL starve_cyc%0d: got %b want %b", k, {bus.i_gnt, bus.d_gnt}, exp);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_flush();
    // Flush in the response cycle
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h10;
    @(negedge clk);
    n_cmp++;
    if (bus.i_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL flush_a_grant: got %b want 1", bus.i_gnt);
    end
    next_cycle();
    idle_inputs();
    bus.i_flush = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_addr  = 30'h20;
    @(negedge clk);
    n_cmp++;
    if ({bus.i_rvalid, bus.i_err, bus.d_gnt} !== 3'b001) begin
      n_err++;
      $display("FAIL flush_a_resp: got %b want 001", {bus.i_rvalid, bus.i_err, bus.d_gnt});
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.d_rdata} !== {2'b01, ref_mem[32'h20]}) begin
      n_err++;
      $display("FAIL flush_data_unaffected: got %b %h want 01 %h",
               {bus.i_rvalid, bus.d_rvalid}, bus.d_rdata, ref_mem[32'h20]);
    end
    next_cycle();
    // Flush in the grant cycle
    bus.i_req   = 1'b1;
    bus.i_addr  = 30'h10;
    bus.i_flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.i_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL flush_b_grant: got %b want 1", bus.i_gnt);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (bus.i_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_b_resp: got %b want 0", bus.i_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_range();
    logic [31:0] wd;
    wd = $urandom;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 30'h400;
    bus.d_wdata = wd;
    bus.d_be    = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if ({bus.d_gnt, bus.mem_write_ready, bus.mem_read_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL range_store_drive: got %b want 100",
               {bus.d_gnt, bus.mem_write_ready, bus.mem_read_ready});
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b11, 32'h0}) begin
      n_err++;
      $display("FAIL range_store_resp: got v%b e%b %h want v1 e1 00000000",
               bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    next_cycle();
    // Aliased word 0 must be untouched
    bus.d_req  = 1'b1;
    bus.d_addr = 30'h0;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, ref_mem[0]}) begin
      n_err++;
      $display("FAIL range_mem_unchanged: got v%b e%b %h want v1 e0 %h",
               bus.d_rvalid, bus.d_err, bus.d_rdata, ref_mem[0]);
    end
    next_cycle();
    // Last in-range word, then far out of range, on the fetch port
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h3FF;
    next_cycle();
    bus.i_addr = 30'h3FFF_FFFF;
    @(negedge clk);
    n_cmp++;
    if ({bus.i_rvalid, bus.i_err, bus.i_rdata} !== {2'b10, ref_mem[WORDS-1]}) begin
      n_err++;
      $display("FAIL range_fetch_top: got v%b e%b %h want v1 e0 %h",
               bus.i_rvalid, bus.i_err, bus.i_rdata, ref_mem[WORDS-1]);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.i_rvalid, bus.i_err, bus.i_rdata} !== {2'b11, 32'h0}) begin
      n_err++;
      $display("FAIL range_fetch_oor: got v%b e%b %h want v1 e1 00000000",
               bus.i_rvalid, bus.i_err, bus.i_rdata);
    end
    next_cycle();
  endtask

  // Reference model: data wins unless the fetch has already lost STARVE_LIMIT
  // times in a row; each accepted transaction's response shows up one cycle later.
  task automatic test_random();
    int          losses     = 0;
    int          prev_owner = 0;   // 0 none, 1 fetch, 2 data
    logic        prev_err   = 1'b0;
    logic [31:0] prev_data  = '0;
    for (int k = 0; k <= 400; k++) begin
      logic        ir, dr, fl, we, eig, edg, oor, last;
      logic [29:0] ia, da, addr;
      logic [31:0] wd;
      logic [3:0]  be;
      last = (k == 400);
      ir = !last && ($urandom_range(0, 3) != 0);
      dr = !last && ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 7) == 0);
      we = $urandom_range(0, 1) == 1;
      ia = ($urandom_range(0, 7) == 0) ? 30'($urandom_range(WORDS, 32'h3FFF_FFFF))
                                       : 30'($urandom_range(0, WORDS - 1));
      da = ($urandom_range(0, 7) == 0) ? 30'($urandom_range(WORDS, 32'h3FFF_FFFF))
                                       : 30'($urandom_range(0, WORDS - 1));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      bus.i_req = ir; bus.i_addr = ia; bus.i_flush = fl;
      bus.d_req = dr; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd; bus.d_be = be;

      eig  = ir && (!dr || losses >= STARVE_LIMIT);
      edg  = dr && !eig;
      addr = eig ? ia : da;
      oor  = 32'(addr) >= WORDS;

      @(negedge clk);
      n_cmp++;
      if ({bus.i_gnt, bus.d_gnt} !== {eig, edg}) begin
        n_err++;
        $display("FAIL rand_grant cyc%0d: got %b want %b", k, {bus.i_gnt, bus.d_gnt}, {eig, edg});
      end
      n_cmp++;
      if ({bus.mem_read_ready, bus.mem_write_ready} !==
          {(eig || edg) && !oor, edg && we && !oor}) begin
        n_err++;
        $display("FAIL rand_mem_en cyc%0d: got %b want %b", k,
                 {bus.mem_read_ready, bus.mem_write_ready},
                 {(eig || edg) && !oor, edg && we && !oor});
      end
      n_cmp++;
      if ({bus.i_rvalid, bus.d_rvalid} !== {prev_owner == 1 && !fl, prev_owner == 2}) begin
        n_err++;
        $display("FAIL rand_rvalid cyc%0d: got %b want %b", k, {bus.i_rvalid, bus.d_rvalid},
                 {prev_owner == 1 && !fl, prev_owner == 2});
      end
      if (prev_owner == 1 && !fl) begin
        n_cmp++;
        if ({bus.i_err, bus.i_rdata} !== {prev_err, prev_data}) begin
          n_err++;
          $display("FAIL rand_i_resp cyc%0d: got e%b %h want e%b %h", k,
                   bus.i_err, bus.i_rdata, prev_err, prev_data);
        end
      end
      if (prev_owner == 2) begin
        n_cmp++;
        if ({bus.d_err, bus.d_rdata} !== {prev_err, prev_data}) begin
          n_err++;
          $display("FAIL rand_d_resp cyc%0d: got e%b %h want e%b %h", k,
                   bus.d_err, bus.d_rdata, prev_err, prev_data);
        end
      end

      prev_err  = oor;
      prev_data = '0;
      if ((eig || edg) && !oor) begin
        if (edg && we) ref_mem[addr[AW-1:0]] = merge(ref_mem[addr[AW-1:0]], wd, be);
        prev_data = ref_mem[addr[AW-1:0]];
      end
      prev_owner = eig ? (fl ? 0 : 1) : (edg ? 2 : 0);
      if (ir && !eig) losses = (losses < STARVE_LIMIT) ? losses + 1 : losses;
      else            losses = 0;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    rst_n = 1'b0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    idle_inputs();
    bus.mem_read_data = '0;
    next_cycle();
    for (int a = 0; a < WORDS; a++) preload(a, $urandom);
    test_reset();
    test_reset_mid();
    test_fetch();
    test_back_to_back();
    test_starvation();
    test_flush();
    test_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
